// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter with burst allowance sharing one synchronous sprite ROM between note lanes.
// Optional transparency-key flag on responses: define TRANSPARENT_KEY_EN.
module sprite_rom_arbiter #(
   parameter int NUM_REQ = 5,
   parameter int ADDR_W = 13,
   parameter int DATA_W = 24,
   parameter int MAX_BURST = 4,
   parameter logic [DATA_W-1:0] KEY_COLOR = 24'hFF00FF
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [ADDR_W-1:0]         rom_addr,
   input  logic [DATA_W-1:0]         rom_data,
   output logic                      rsp_valid,
   output logic [2:0]                rsp_id,
   output logic [DATA_W-1:0]         rsp_data
`ifdef TRANSPARENT_KEY_EN
   ,
   output logic                      rsp_transparent
`endif
);

   localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

   logic [2:0] owner;
   logic       owner_valid;
   logic [3:0] burst_cnt;

   logic       s1_valid;
   logic [2:0] s1_id;

   logic       owner_req;
   logic       hold;
   logic       any_grant;
   logic       hi_found;
   logic       lo_found;
   logic [2:0] hi_idx;
   logic [2:0] lo_idx;
   logic [2:0] gnt_idx;

   // Round-robin from owner+1: first requester above owner wins, else the
   // lowest requester at or below owner (wrapping back to owner itself).
   always_comb begin
      owner_req = 1'b0;
      hi_found  = 1'b0;
      lo_found  = 1'b0;
      hi_idx    = '0;
      lo_idx    = '0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (3'(j) == owner)
            owner_req = req[j];
         if (req[j] && (3'(j) > owner) && !hi_found) begin
            hi_found = 1'b1;
            hi_idx   = 3'(j);
         end
         if (req[j] && (3'(j) <= owner) && !lo_found) begin
            lo_found = 1'b1;
            lo_idx   = 3'(j);
         end
      end
   end

   always_comb begin
      any_grant = !Reset && (req != '0);
      hold      = owner_valid && owner_req && (burst_cnt < BURST_LAST);
      if (hold)
         gnt_idx = owner;
      else if (hi_found)
         gnt_idx = hi_idx;
      else
         gnt_idx = lo_idx;
   end

   always_comb begin
      gnt      = '0;
      rom_addr = '0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (any_grant && (3'(j) == gnt_idx)) begin
            gnt[j]   = 1'b1;
            rom_addr = req_addr[j*ADDR_W +: ADDR_W];
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         owner       <= '0;
         owner_valid <= 1'b0;
         burst_cnt   <= '0;
      end else if (any_grant) begin
         if (owner_valid && (gnt_idx == owner)) begin
            // Window restarts after the last allowed beat, so a lone lane keeps streaming.
            burst_cnt <= (burst_cnt == BURST_LAST) ? 4'd0 : burst_cnt + 4'd1;
         end else begin
            owner       <= gnt_idx;
            owner_valid <= 1'b1;
            burst_cnt   <= '0;
         end
      end else begin
         owner_valid <= 1'b0;
         burst_cnt   <= '0;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         s1_valid  <= 1'b0;
         s1_id     <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else begin
         s1_valid  <= any_grant;
         s1_id     <= any_grant ? gnt_idx : 3'd0;
         rsp_valid <= s1_valid;
         rsp_id    <= s1_id;
         if (s1_valid)
            rsp_data <= rom_data;
      end
   end

`ifdef TRANSPARENT_KEY_EN
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         rsp_transparent <= 1'b0;
      else
         rsp_transparent <= s1_valid && (rom_data == KEY_COLOR);
   end
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench: two arbiters (MAX_BURST 4 and 1) on shared stimulus, checked
// every cycle against a rule-level model plus directed literal expectations.
module tb_sprite_rom_arbiter;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [4:0]  req;
   logic [64:0] req_addr;

   logic [4:0]  gnt [2];
   logic [12:0] rom_addr [2];
   logic [23:0] rom_data [2];
   logic        rsp_valid [2];
   logic [2:0]  rsp_id [2];
   logic [23:0] rsp_data [2];
`ifdef TRANSPARENT_KEY_EN
   logic        rsp_tr [2];
`endif

   int n_checks = 0;
   int n_fail = 0;

   sprite_rom_arbiter #(.NUM_REQ(5), .ADDR_W(13), .DATA_W(24), .MAX_BURST(4)) dut0 (
      .Clk(Clk), .Reset(Reset), .req(req), .req_addr(req_addr),
      .gnt(gnt[0]), .rom_addr(rom_addr[0]), .rom_data(rom_data[0]),
      .rsp_valid(rsp_valid[0]), .rsp_id(rsp_id[0]), .rsp_data(rsp_data[0])
`ifdef TRANSPARENT_KEY_EN
      , .rsp_transparent(rsp_tr[0])
`endif
   );

   sprite_rom_arbiter #(.NUM_REQ(5), .ADDR_W(13), .DATA_W(24), .MAX_BURST(1)) dut1 (
      .Clk(Clk), .Reset(Reset), .req(req), .req_addr(req_addr),
      .gnt(gnt[1]), .rom_addr(rom_addr[1]), .rom_data(rom_data[1]),
      .rsp_valid(rsp_valid[1]), .rsp_id(rsp_id[1]), .rsp_data(rsp_data[1])
`ifdef TRANSPARENT_KEY_EN
      , .rsp_transparent(rsp_tr[1])
`endif
   );

   always #5 Clk = ~Clk;

   function automatic logic [23:0] romf(input logic [12:0] a);
      if (a == 13'h010) return 24'hFF00FF;
      if (a == 13'h011) return 24'h0000FF;
      return {~a[10:0], a};
   endfunction

   always @(posedge Clk) begin
      rom_data[0] <= romf(rom_addr[0]);
      rom_data[1] <= romf(rom_addr[1]);
   end

   task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", name, d, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_owner [2];
   bit          m_ov [2];
   int          m_bc [2];
   int          maxb [2] = '{4, 1};
   bit          hv [2][0:1023];
   int          hid [2][0:1023];
   logic [12:0] ha [2][0:1023];
   logic [23:0] last [2];
   int          cyc = 0;

   function automatic int model_grant(input int d);
      int idx;
      if (req == 5'd0) return -1;
      if (m_ov[d] && req[m_owner[d]] && (m_bc[d] < maxb[d] - 1)) return m_owner[d];
      for (int k = 1; k <= 5; k++) begin
         idx = (m_owner[d] + k) % 5;
         if (req[idx]) return idx;
      end
      return -1;
   endfunction

   always @(negedge Clk) begin
      for (int d = 0; d < 2; d++) begin
         int          g;
         bit          pv;
         logic [12:0] ea;
         if (Reset) begin
            check("rst_gnt", d, gnt[d], 0);
            check("rst_addr", d, rom_addr[d], 0);
            check("rst_valid", d, rsp_valid[d], 0);
            check("rst_data", d, rsp_data[d], 0);
`ifdef TRANSPARENT_KEY_EN
            check("rst_transp", d, rsp_tr[d], 0);
`endif
            m_owner[d] = 0; m_ov[d] = 0; m_bc[d] = 0; last[d] = '0;
            hv[d][cyc] = 0;
            if (cyc > 0) hv[d][cyc-1] = 0;
         end else begin
            g  = model_grant(d);
            ea = (g < 0) ? 13'd0 : req_addr[g*13 +: 13];
            check("gnt", d, gnt[d], (g < 0) ? 0 : (1 << g));
            check("rom_addr", d, rom_addr[d], ea);
            hv[d][cyc]  = (g >= 0);
            hid[d][cyc] = g;
            ha[d][cyc]  = ea;
            pv = (cyc >= 2) && hv[d][cyc-2];
            check("rsp_valid", d, rsp_valid[d], pv);
            if (pv) begin
               check("rsp_id", d, rsp_id[d], hid[d][cyc-2]);
               last[d] = romf(ha[d][cyc-2]);
            end
            check("rsp_data", d, rsp_data[d], last[d]);
`ifdef TRANSPARENT_KEY_EN
            check("rsp_transp", d, rsp_tr[d], pv && (last[d] == 24'hFF00FF));
`endif
            if (g >= 0) begin
               if (m_ov[d] && g == m_owner[d])
                  m_bc[d] = (m_bc[d] == maxb[d] - 1) ? 0 : m_bc[d] + 1;
               else begin
                  m_owner[d] = g; m_ov[d] = 1; m_bc[d] = 0;
               end
            end else begin
               m_ov[d] = 0; m_bc[d] = 0;
            end
         end
      end
      cyc++;
   end

   // ---------------- directed stimulus ----------------
   int seed = 1;

   function automatic logic [64:0] mk(input int s);
      logic [64:0] a;
      for (int i = 0; i < 5; i++) a[i*13 +: 13] = 13'(s * 16 + i * 3 + 1);
      return a;
   endfunction

   task automatic step(input logic [4:0] r);
      @(posedge Clk); #1;
      req = r;
      req_addr = mk(seed);
      seed++;
      @(negedge Clk);
   endtask

   task automatic step_a(input logic [4:0] r, input logic [64:0] a);
      @(posedge Clk); #1;
      req = r;
      req_addr = a;
      @(negedge Clk);
   endtask

   task automatic scenario_single;
      logic [64:0] a;
      a = mk(99);
      a[26 +: 13] = 13'h040;
      step_a(5'b00100, a);
      check("s1_gnt", 0, gnt[0], 5'b00100);
      check("s1_addr", 0, rom_addr[0], 13'h040);
      step(5'b00000);
      check("s1_valid_early", 0, rsp_valid[0], 0);
      step(5'b00000);
      check("s1_valid", 0, rsp_valid[0], 1);
      check("s1_id", 0, rsp_id[0], 2);
      check("s1_data", 0, rsp_data[0], 24'hF7E040);
   endtask

   int exp_s2 [10] = '{0, 0, 0, 0, 3, 3, 3, 3, 0, 0};
   int exp_s4 [5]  = '{0, 1, 2, 3, 4};

   initial begin
      Reset = 1'b1;
      req = '0;
      req_addr = '0;
      repeat (2) @(negedge Clk);
      check("init_valid", 0, rsp_valid[0], 0);
      check("init_id", 0, rsp_id[0], 0);
      check("init_gnt", 0, gnt[0], 0);
      @(posedge Clk); #1;
      Reset = 1'b0;

      scenario_single();

      // lane 4 first so the search for lanes 0/3 starts at lane 0
      step(5'b10000);
      for (int i = 0; i < 10; i++) begin
         step(5'b01001);
         check("s2_gnt", 0, gnt[0], 1 << exp_s2[i]);
      end

      step(5'b00000);
      for (int i = 0; i < 10; i++) begin
         step(5'b00010);
         check("s3_gnt", 0, gnt[0], 5'b00010);
      end
      repeat (3) step(5'b00000);

      step(5'b10000);
      for (int i = 0; i < 5; i++) begin
         step(5'b11111);
         check("s4_rr_gnt", 1, gnt[1], 1 << exp_s4[i]);
      end
      step(5'b00000);
      step(5'b10001);
      check("s4_after_idle", 1, gnt[1], 5'b00001);
      repeat (3) step(5'b00000);

      // reset with two reads in flight
      step(5'b00001);
      step(5'b00010);
      @(posedge Clk); #1;
      Reset = 1'b1;
      req = 5'b11111;
      @(negedge Clk);
      check("mid_rst_gnt", 0, gnt[0], 0);
      check("mid_rst_valid", 0, rsp_valid[0], 0);
      @(negedge Clk);
      check("mid_rst_data", 0, rsp_data[0], 0);
      @(posedge Clk); #1;
      Reset = 1'b0;
      req = '0;
      @(negedge Clk);
      check("post_rst_valid0", 0, rsp_valid[0], 0);
      step(5'b00000);
      check("post_rst_valid1", 0, rsp_valid[0], 0);
      step(5'b00000);
      check("post_rst_valid2", 0, rsp_valid[0], 0);
      scenario_single();

      step_a(5'b00001, {52'd0, 13'h010});
      step_a(5'b00001, {52'd0, 13'h011});
      step(5'b00000);
      check("key_data", 0, rsp_data[0], 24'hFF00FF);
`ifdef TRANSPARENT_KEY_EN
      check("key_transp", 0, rsp_tr[0], 1);
`endif
      step(5'b00000);
      check("nonkey_data", 0, rsp_data[0], 24'h0000FF);
`ifdef TRANSPARENT_KEY_EN
      check("nonkey_transp", 0, rsp_tr[0], 0);
`endif
      repeat (3) step(5'b00000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
